// File: rtl/ccff_loader.sv
// ccff_loader: drives the head of a configuration flip-flop chain and
// observes its tail.
//   LOAD     : bitstream words are serialised LSB-first into the chain. A
//              CRC-16-CCITT of every bit shifted in is kept.
//   READBACK : the chain is rotated once through a tail->head loopback. The
//              CRC is recomputed from ccff_tail and compared with the CRC of
//              the last completed LOAD.
// Ports:
//   prog_clk, pReset      programming clock, synchronous active-low reset
//   start, mode           one-cycle request (0 = LOAD, 1 = READBACK), IDLE only
//   cfg_data/valid/ready  bitstream word handshake
//   ccff_head             serial bit into the chain
//   ccff_shift_en         chain advances at the edge ending this cycle
//   ccff_tail             serial bit out of the chain
//   busy, done, crc_ok    status; done pulses for one cycle per operation
//   crc_value             CRC of the last completed LOAD
module ccff_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              mode,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              crc_ok,
  output logic [15:0]       crc_value
);

  localparam int              IDX_W     = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] FULL_WORD = IDX_W'(WORD_W);
  localparam logic [IDX_W-1:0] ONE_BIT   = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, READBACK, FINISH} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] buf_data;
  logic [IDX_W-1:0]  buf_cnt;   // unsent bits left in buf_data
  logic [CNT_W-1:0]  bit_cnt;
  logic [15:0]       crc_acc;
  logic              op_rb;     // current operation is a READBACK
  logic              shift_raw; // shift request before reset gating
  logic              last_bit;
  logic              accept;

  // Bit-serial CRC-16-CCITT step: poly 0x1021, MSB-first, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge prog_clk) begin
    if (!pReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    ccff_head = 1'b0;
    shift_raw = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    crc_ok    = 1'b0;
    last_bit  = (bit_cnt == LAST_BIT);
    case (state)
      IDLE: begin
        if (start) state_nxt = mode ? READBACK : LOAD;
      end
      LOAD: begin
        shift_raw = (buf_cnt != '0);
        ccff_head = buf_data[0] & shift_raw;
        // Taking a new word while the last buffered bit leaves avoids a
        // one-cycle bubble between back-to-back words.
        cfg_ready = (buf_cnt == '0) || (buf_cnt == ONE_BIT);
        if (shift_raw && last_bit) state_nxt = FINISH;
      end
      READBACK: begin
        shift_raw = 1'b1;
        ccff_head = ccff_tail;
        if (last_bit) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        crc_ok    = op_rb && (crc_acc == crc_value);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = cfg_valid && cfg_ready;

  // Reset drops the chain clock enable in the same cycle so the chain
  // cannot take a spurious shift at the reset edge.
  assign ccff_shift_en = shift_raw & pReset;

  // Control registers.
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      buf_cnt   <= '0;
      op_rb     <= 1'b0;
      crc_value <= 16'hFFFF;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_rb   <= mode;
            buf_cnt <= '0;
          end
        end
        LOAD: begin
          // Bits left over in the final word are dropped.
          if (shift_raw && last_bit) buf_cnt <= '0;
          else if (accept)           buf_cnt <= FULL_WORD;
          else if (shift_raw)        buf_cnt <= buf_cnt - ONE_BIT;
        end
        FINISH: begin
          if (!op_rb) crc_value <= crc_acc;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; always re-initialised by start before use.
  always_ff @(posedge prog_clk) begin
    if (state == IDLE && start) begin
      bit_cnt <= '0;
      crc_acc <= 16'hFFFF;
    end else if (shift_raw) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
      crc_acc <= crc16_step(crc_acc, ccff_head);
    end
    if (accept)                          buf_data <= cfg_data;
    else if (shift_raw && state == LOAD) buf_data <= buf_data >> 1;
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: one instance with an 8-bit chain model, one with a
// 12-bit chain model. Expected head bits are queued when stimulus is driven
// and checked on every cycle the DUT shifts.
module tb_ccff_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: CHAIN_LEN = 8
  logic       a_start, a_mode, a_valid, a_ready, a_head, a_sen, a_tail;
  logic       a_busy, a_done, a_ok;
  logic [7:0] a_data;
  logic [15:0] a_crc;
  logic [7:0] chain_a = '0;
  logic       flip_a = 1'b0;

  // Instance B: CHAIN_LEN = 12
  logic       b_start, b_mode, b_valid, b_ready, b_head, b_sen, b_tail;
  logic       b_busy, b_done, b_ok;
  logic [7:0] b_data;
  logic [15:0] b_crc;
  logic [11:0] chain_b = '0;

  ccff_loader #(.CHAIN_LEN(8), .WORD_W(8), .CNT_W(16)) dut_a (
    .prog_clk(clk), .pReset(rst_n), .start(a_start), .mode(a_mode),
    .cfg_data(a_data), .cfg_valid(a_valid), .cfg_ready(a_ready),
    .ccff_head(a_head), .ccff_shift_en(a_sen), .ccff_tail(a_tail),
    .busy(a_busy), .done(a_done), .crc_ok(a_ok), .crc_value(a_crc));

  ccff_loader #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(16)) dut_b (
    .prog_clk(clk), .pReset(rst_n), .start(b_start), .mode(b_mode),
    .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .ccff_head(b_head), .ccff_shift_en(b_sen), .ccff_tail(b_tail),
    .busy(b_busy), .done(b_done), .crc_ok(b_ok), .crc_value(b_crc));

  // Behavioural chains: new bit enters at the MSB, tail is bit 0.
  always @(posedge clk) begin
    if (flip_a)     chain_a[3] <= ~chain_a[3];
    else if (a_sen) chain_a <= {a_head, chain_a[7:1]};
  end
  always @(posedge clk) begin
    if (b_sen) chain_b <= {b_head, chain_b[11:1]};
  end
  assign a_tail = chain_a[0];
  assign b_tail = chain_b[0];

  int   n_chk = 0;
  int   n_pass = 0;
  logic qa[$];
  logic qb[$];
  int   sh_a, sh_b, done_a, done_b, stall_b;

  function automatic logic [15:0] ref_crc(input logic [31:0] bits, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_a(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) qa.push_back(v[i]);
  endtask
  task automatic push_b(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) qb.push_back(v[i]);
  endtask

  // Scoreboard: runs at the falling edge of every cycle.
  task automatic mon();
    logic e;
    if (a_sen) begin
      sh_a++;
      check("a_shift_expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_head_bit", a_head, e);
      end
    end
    if (a_done) done_a++;
    if (b_sen) begin
      sh_b++;
      check("b_shift_expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_head_bit", b_head, e);
      end
    end
    if (b_busy && !b_sen && sh_b > 0 && sh_b < 12) stall_b++;
    if (b_done) done_b++;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask
  task automatic next();
    mon();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    to_neg();
    next();
  endtask

  task automatic wait_done_a(input int max, output int lat, output logic ok);
    lat = -1;
    ok  = 1'bx;
    for (int i = 0; i < max; i++) begin
      to_neg();
      if (a_done) begin
        lat = i;
        ok  = a_ok;
      end
      next();
      if (lat >= 0) break;
    end
    check("a_done_seen", lat >= 0, 1);
  endtask

  task automatic wait_done_b(input int max, output int lat, output logic ok);
    lat = -1;
    ok  = 1'bx;
    for (int i = 0; i < max; i++) begin
      to_neg();
      if (b_done) begin
        lat = i;
        ok  = b_ok;
      end
      next();
      if (lat >= 0) break;
    end
    check("b_done_seen", lat >= 0, 1);
  endtask

  task automatic start_load_a(input logic [7:0] w);
    a_start = 1'b1; a_mode = 1'b0;
    tick();
    a_start = 1'b0;
    a_data = w; a_valid = 1'b1;
    push_a({24'h0, w}, 8);
    to_neg();
    check("a_ready_after_start", a_ready, 1);
    check("a_no_shift_before_word", a_sen, 0);
    next();
    a_valid = 1'b0;
  endtask

  int   lat;
  logic okd;

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_mode = 0; a_data = '0; a_valid = 0;
    b_start = 0; b_mode = 0; b_data = '0; b_valid = 0;
    sh_a = 0; sh_b = 0; done_a = 0; done_b = 0; stall_b = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    to_neg();
    check("rst_ready", a_ready, 0);
    check("rst_head", a_head, 0);
    check("rst_sen", a_sen, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_ok", a_ok, 0);
    check("rst_crc", a_crc, 16'hFFFF);
    check("rst_crc_b", b_crc, 16'hFFFF);
    next();
    rst_n = 1'b1;
    tick();

    // Basic LOAD of 0xA5
    start_load_a(8'hA5);
    wait_done_a(20, lat, okd);
    check("a_load_latency", lat, 8);
    check("a_ok_after_load", okd, 0);
    to_neg();
    check("a_busy_after_done", a_busy, 0);
    check("a_crc_load", a_crc, ref_crc(32'hA5, 8));
    check("a_chain_load", chain_a, 8'hA5);
    check("a_shift_count", sh_a, 8);
    check("a_done_count", done_a, 1);
    check("a_sb_drained", qa.size(), 0);
    next();

    // Clean READBACK
    sh_a = 0; done_a = 0;
    a_start = 1'b1; a_mode = 1'b1;
    push_a(32'hA5, 8);
    tick();
    a_start = 1'b0;
    wait_done_a(20, lat, okd);
    check("rb_latency", lat, 8);
    check("rb_crc_ok", okd, 1);
    to_neg();
    check("rb_chain_kept", chain_a, 8'hA5);
    check("rb_shift_count", sh_a, 8);
    check("rb_crc_value_kept", a_crc, ref_crc(32'hA5, 8));
    check("rb_ok_cleared", a_ok, 0);
    next();

    // Corrupted READBACK
    flip_a = 1'b1;
    tick();
    flip_a = 1'b0;
    to_neg();
    check("bad_chain_flipped", chain_a, 8'hAD);
    next();
    a_start = 1'b1; a_mode = 1'b1;
    push_a(32'hAD, 8);
    tick();
    a_start = 1'b0;
    wait_done_a(20, lat, okd);
    check("bad_crc_ok", okd, 0);
    to_neg();
    check("bad_crc_value_kept", a_crc, ref_crc(32'hA5, 8));
    next();

    // Reset after 4 of 8 shifts
    sh_a = 0; done_a = 0;
    start_load_a(8'hA5);
    repeat (4) tick();
    rst_n = 1'b0;
    to_neg();
    check("mid_rst_sen_drop", a_sen, 0);
    next();
    rst_n = 1'b1;
    to_neg();
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_ready", a_ready, 0);
    check("mid_rst_sen", a_sen, 0);
    check("mid_rst_head", a_head, 0);
    check("mid_rst_done", a_done, 0);
    check("mid_rst_crc", a_crc, 16'hFFFF);
    check("mid_rst_shifts", sh_a, 4);
    qa.delete();
    next();

    // start while busy is ignored
    sh_a = 0; done_a = 0;
    start_load_a(8'h3C);
    repeat (3) tick();
    a_start = 1'b1; a_mode = 1'b1;
    tick();
    a_start = 1'b0;
    wait_done_a(20, lat, okd);
    repeat (4) tick();
    to_neg();
    check("busy_start_done_count", done_a, 1);
    check("busy_start_shifts", sh_a, 8);
    check("busy_start_idle", a_busy, 0);
    check("busy_start_chain", chain_a, 8'h3C);
    check("busy_start_crc", a_crc, ref_crc(32'h3C, 8));
    next();

    // Partial final word with stall (CHAIN_LEN = 12)
    b_start = 1'b1; b_mode = 1'b0;
    tick();
    b_start = 1'b0;
    b_data = 8'hFF; b_valid = 1'b1;
    push_b(32'hFFF, 12);
    tick();
    b_valid = 1'b0;
    repeat (10) tick();
    b_data = 8'h0F; b_valid = 1'b1;
    to_neg();
    check("b_ready_when_empty", b_ready, 1);
    check("b_stalled", b_sen, 0);
    next();
    b_valid = 1'b0;
    wait_done_b(20, lat, okd);
    check("b_tail_latency", lat, 4);
    check("b_ok_after_load", okd, 0);
    to_neg();
    check("b_shift_count", sh_b, 12);
    check("b_stall_cycles", stall_b, 3);
    check("b_chain", chain_b, 12'hFFF);
    check("b_crc", b_crc, ref_crc(32'hFFF, 12));
    check("b_done_count", done_b, 1);
    check("b_sb_drained", qb.size(), 0);
    next();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader and readback checker. It drives the `ccff_head` end of a tile's configuration flip-flop chain and observes its `ccff_tail` end. A word stream from the bitstream source is serialised LSB-first into the chain, and a running CRC-16 of every bit shifted in is kept. A later non-destructive circular readback recomputes the CRC from `ccff_tail` and reports whether it matches the load.

## Interface

Parameters:
- `CHAIN_LEN`, default 16: number of config bits in the attached chain; must be ≥ 2.
- `WORD_W`, default 8: width of a bitstream word.
- `CNT_W`, default 16: bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- `prog_clk`  in  1: programming clock; the only clock.
- `pReset`  in  1: reset, synchronous and active-low.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `mode`  in  1: sampled with `start`; 0 = LOAD, 1 = READBACK.
- `cfg_data`  in  WORD_W: bitstream word; bit 0 is shifted first.
- `cfg_valid`  in  1: `cfg_data` is valid.
- `cfg_ready`  out  1: loader accepts `cfg_data` this cycle.
- `ccff_head`  out  1: serial bit into the chain.
- `ccff_shift_en`  out  1: chain advances at the `prog_clk` edge ending this cycle; integration gates the chain's `prog_clk` with it.
- `ccff_tail`  in  1: serial bit out of the chain.
- `busy`  out  1: high in any non-IDLE state.
- `done`  out  1: one-cycle pulse when an operation completes.
- `crc_ok`  out  1: readback CRC matched; valid while `done`=1 after a READBACK, otherwise 0.
- `crc_value`  out  16: CRC of the last completed LOAD.

## Operation

- **States:** IDLE, LOAD, READBACK, FINISH.
- **IDLE:**
  - `start`=1 with `mode`=0 goes to LOAD; `bit_cnt` is cleared, `crc_acc` is set to 0xFFFF, and the word buffer is emptied.
  - `start`=1 with `mode`=1 goes to READBACK; `bit_cnt` is cleared and `crc_acc` is set to 0xFFFF.
- **LOAD:**
  - Word buffer: a WORD_W shift register plus a bit index.
  - `cfg_ready` = 1 when the buffer is empty, or when it holds exactly one unsent bit that shifts this cycle (zero-bubble back-to-back words).
  - A word is accepted when `cfg_valid` and `cfg_ready` are both 1.
  - In each cycle where the buffer holds a bit: `ccff_shift_en`=1, `ccff_head` = buffer bit 0, the buffer shifts right, `crc_acc` is updated, and `bit_cnt` increments.
  - Empty buffer (underflow): `ccff_shift_en`=0 and the chain holds; this stall is not an error.
  - When the bit with `bit_cnt` = CHAIN_LEN-1 shifts, go to FINISH. Any unsent bits of the final word are discarded.
- **READBACK:**
  - `ccff_head` = `ccff_tail`, a combinational loopback.
  - `ccff_shift_en`=1 for exactly CHAIN_LEN consecutive cycles; `crc_acc` is updated with `ccff_tail` each cycle; `cfg_ready`=0.
  - Bit i out of `ccff_tail` equals bit i loaded, so the order matches LOAD.
  - After CHAIN_LEN rotations the chain contents are unchanged. Then go to FINISH.
- **FINISH (one cycle):**
  - `done`=1.
  - After a LOAD, `crc_value` is set to `crc_acc`.
  - After a READBACK, `crc_ok` = (`crc_acc` == `crc_value`) and `crc_value` is unchanged.
  - Next state is IDLE.
- **CRC:** CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, bit-serial, no reflection, no final XOR.
  - fb = `crc`[15] ^ bit.
  - `crc` = {`crc`[14:0], 0} ^ (fb ? 0x1021 : 0).
- **`ccff_head` source:** a combinational mux of buffer bit 0 (LOAD) and `ccff_tail` (READBACK); it is 0 in IDLE and FINISH.
- **`start` outside IDLE:** ignored; it is neither queued nor an error.

## Timing

- **Reset values** (`pReset`=0 at a `prog_clk` edge):
  - state = IDLE.
  - `cfg_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done`, `crc_ok` = 0.
  - `crc_value` = 0xFFFF.
  - Word buffer empty.
- **Reset mid-operation:** the loader returns to IDLE next cycle and `ccff_shift_en` drops at once. Chain contents are then undefined; `crc_value` = 0xFFFF.
- **`start` → first shift:**
  - LOAD: first shift is 1 cycle after the first accepted word. `cfg_ready`=1 is in the cycle after `start`; the word is accepted that cycle and shifts the following cycle.
  - READBACK: first shift is in the cycle after `start`.
- **LOAD length:** with no stalls, LOAD lasts CHAIN_LEN shift cycles. `done` is asserted the cycle after the last shift. `busy` falls in the cycle after `done`.
- **READBACK length:** CHAIN_LEN cycles, then FINISH, then IDLE. `start` → `done` = CHAIN_LEN+1 cycles.
- **Back-to-back operations:** a new `start` is accepted in the first IDLE cycle after `done`.

## Test plan

- **Basic LOAD.** CHAIN_LEN=8, WORD_W=8, LOAD word 0xA5 with a behavioural 8-bit chain model → `ccff_head` bits 1,0,1,0,0,1,0,1 over 8 cycles with `ccff_shift_en`=1; chain = 0xA5; one-cycle `done`; `crc_value` equals the reference-model CRC.
- **Partial final word and stall.** CHAIN_LEN=12, WORD_W=8, words 0xFF then 0x0F, `cfg_valid` held low 3 cycles between them → `ccff_shift_en` low for exactly 3 cycles; 12 shifts total; upper nibble 0x0 of the second word is never shifted; chain = 0xFFF.
- **Clean READBACK.** Load 0xA5, then READBACK → 8 loopback shifts; chain still 0xA5; `crc_ok`=1 with `done`.
- **Corrupted READBACK.** Load 0xA5, flip chain bit 3 in the model, then READBACK → `crc_ok`=0; `crc_value` unchanged.
- **Reset mid-LOAD.** `pReset`=0 after 4 of 8 shifts → next cycle all outputs are at reset values, `crc_value`=0xFFFF, state IDLE.
- **`start` while busy.** Assert `start` during LOAD → ignored; exactly one `done` and CHAIN_LEN shifts occur.
